// File: rtl/music_pkg.sv
// music_pkg -- shared constants and types for the music sequencer.
//   * note codes (0 = silence)
//   * song index constants and the song length table
//   * FSM state enum
//   * song_len(): song length lookup; unknown or out-of-range songs are
//     one beat long
package music_pkg;

    // Note codes
    localparam int unsigned S  = 0;
    localparam int unsigned F4 = 4;
    localparam int unsigned G4 = 5;
    localparam int unsigned A4 = 6;
    localparam int unsigned B4 = 7;
    localparam int unsigned C5 = 8;

    // Song indices
    localparam int unsigned SONG_WAIT       = 0;
    localparam int unsigned SONG_SCORE      = 1;
    localparam int unsigned SONG_OVER       = 2;
    localparam int unsigned NUM_TABLE_SONGS = 3;

    // Length in beats of each song that has a table entry
    localparam int unsigned SONG_LEN [NUM_TABLE_SONGS] = '{16, 8, 8};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    // Any song without a table entry, or outside the configured song
    // count, is a silent one-beat song.
    function automatic int unsigned song_len(input int unsigned song,
                                             input int unsigned num_songs);
        if (song >= num_songs || song >= NUM_TABLE_SONGS)
            return 1;
        return SONG_LEN[song];
    endfunction

endpackage

// File: rtl/music_rom.sv
// music_rom -- purely combinational song table.
// Ports:
//   song : song index
//   beat : beat index within the song
//   note : note code for (song, beat); S for unknown songs
module music_rom
    import music_pkg::*;
#(
    parameter int NOTE_W    = 5,
    parameter int BEAT_W    = 8,
    parameter int NUM_SONGS = 4,
    parameter int SEL_W     = 2
) (
    input  logic [SEL_W-1:0]  song,
    input  logic [BEAT_W-1:0] beat,
    output logic [NOTE_W-1:0] note
);

    localparam int unsigned SCORE_TBL [8] = '{F4, A4, C5, A4, F4, A4, C5, S};
    localparam int unsigned OVER_TBL  [8] = '{C5, B4, A4, G4, F4, F4, S, S};

    int unsigned song_idx;
    int unsigned beat_idx;
    int unsigned code;

    always_comb begin
        song_idx = 32'(song);
        beat_idx = 32'(beat);
        code     = S;
        if (song_idx < NUM_SONGS) begin
            case (song_idx)
                SONG_WAIT: begin
                    // Beat 0 is a rest, then A4 on even beats, F4 on odd.
                    if (beat_idx == 0)    code = S;
                    else if (beat_idx[0]) code = F4;
                    else                  code = A4;
                end
                SONG_SCORE: code = SCORE_TBL[beat_idx % 8];
                SONG_OVER:  code = OVER_TBL[beat_idx % 8];
                default:    code = S;
            endcase
        end
        note = NOTE_W'(code);
    end

endmodule

// File: rtl/music_seq.sv
// music_seq -- tempo-driven song sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   song_sel   : song to play, latched when a start is accepted
//   start      : pulse, (re)start song_sel from beat 0
//   stop       : pulse, abort playback (wins over start)
//   loop_en    : repeat the song when set, latched with start
//   note       : registered note code, S when idle
//   beat_cnt   : current beat within the song
//   busy       : high while playing
//   done       : one-cycle pulse when a one-shot song completes
module music_seq
    import music_pkg::*;
#(
    parameter int NOTE_W    = 5,
    parameter int BEAT_W    = 8,
    parameter int TEMPO_DIV = 25_000_000,
    parameter int NUM_SONGS = 4,
    localparam int SEL_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEL_W-1:0]  song_sel,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [NOTE_W-1:0] note,
    output logic [BEAT_W-1:0] beat_cnt,
    output logic              busy,
    output logic              done
);

    localparam int PRE_W = $clog2(TEMPO_DIV);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  song_q,  song_d;
    logic              loop_q,  loop_d;
    logic [PRE_W-1:0]  pre_q,   pre_d;
    logic [BEAT_W-1:0] beat_q,  beat_d;
    logic [NOTE_W-1:0] note_q,  note_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [NOTE_W-1:0] rom_note;
    logic [BEAT_W-1:0] last_beat;
    logic              pre_wrap;
    logic              start_acc;

    music_rom #(
        .NOTE_W    (NOTE_W),
        .BEAT_W    (BEAT_W),
        .NUM_SONGS (NUM_SONGS),
        .SEL_W     (SEL_W)
    ) u_rom (
        .song (song_q),
        .beat (beat_q),
        .note (rom_note)
    );

    assign last_beat = BEAT_W'(song_len(32'(song_q), NUM_SONGS) - 1);
    assign pre_wrap  = (pre_q == PRE_W'(TEMPO_DIV - 1));
    assign start_acc = start && !stop;

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        loop_d  = loop_q;
        pre_d   = pre_q;
        beat_d  = beat_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = ST_PLAY;
                    song_d  = song_sel;
                    loop_d  = loop_en;
                    pre_d   = '0;
                    beat_d  = '0;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                    beat_d  = '0;
                end else if (start) begin
                    // Restart: relatch selection, no done pulse.
                    song_d  = song_sel;
                    loop_d  = loop_en;
                    pre_d   = '0;
                    beat_d  = '0;
                end else if (pre_wrap) begin
                    pre_d = '0;
                    if (beat_q == last_beat) begin
                        beat_d = '0;
                        if (!loop_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // note trails beat_cnt by one cycle. On the cycle after a start the
        // ROM still sees the previous song/beat, so that slot is forced silent.
        note_d = (state_d == ST_PLAY && !start_acc) ? rom_note : NOTE_W'(S);
        busy_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            song_q  <= '0;
            loop_q  <= 1'b0;
            pre_q   <= '0;
            beat_q  <= '0;
            note_q  <= NOTE_W'(S);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            loop_q  <= loop_d;
            pre_q   <= pre_d;
            beat_q  <= beat_d;
            note_q  <= note_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign note     = note_q;
    assign beat_cnt = beat_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_music_seq.sv
// tb_music_seq -- directed test of music_seq with TEMPO_DIV = 4.
// A behavioural model tracks play position in cycles since start and
// derives beat/note/busy/done arithmetically; a compare process checks
// it every cycle, and literal checks pin key points of the model.
module tb_music_seq;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] song_sel = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [4:0] note;
    logic [7:0] beat_cnt;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    music_seq #(
        .NOTE_W    (5),
        .BEAT_W    (8),
        .TEMPO_DIV (TD),
        .NUM_SONGS (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .song_sel (song_sel),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .note     (note),
        .beat_cnt (beat_cnt),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    localparam int SCORE [8] = '{4, 6, 8, 6, 4, 6, 8, 0};
    localparam int OVER  [8] = '{8, 7, 6, 5, 4, 4, 0, 0};

    function automatic int song_len(input int s);
        case (s)
            0: return 16;
            1: return 8;
            2: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int song_note(input int s, input int b);
        case (s)
            0: return (b == 0) ? 0 : ((b % 2 == 1) ? 4 : 6);
            1: return SCORE[b];
            2: return OVER[b];
            default: return 0;
        endcase
    endfunction

    bit m_play, m_loop, m_done;
    int m_song, m_pos;   // m_pos = play cycles since start (0 = first cycle)

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_play = 0; m_loop = 0; m_done = 0; m_song = 0; m_pos = 0;
        end else begin
            m_done = 0;
            if (stop) begin
                m_play = 0;
            end else if (start) begin
                m_play = 1; m_song = int'(song_sel); m_loop = loop_en; m_pos = 0;
            end else if (m_play) begin
                m_pos++;
                if (!m_loop && m_pos == song_len(m_song) * TD) begin
                    m_play = 0;
                    m_done = 1;
                end
            end
        end
    end

    function automatic int exp_beat();
        return m_play ? (m_pos / TD) % song_len(m_song) : 0;
    endfunction

    function automatic int exp_note();
        if (!m_play || m_pos == 0) return 0;
        return song_note(m_song, ((m_pos - 1) / TD) % song_len(m_song));
    endfunction

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("busy",     int'(busy),     int'(m_play));
            chk("beat_cnt", int'(beat_cnt), exp_beat());
            chk("note",     int'(note),     exp_note());
            chk("done",     int'(done),     int'(m_done));
        end
    end

    // ---------------- stimulus ----------------
    // Returns on the negedge of the first PLAY cycle.
    task automatic start_song(input int sel, input bit lp);
        @(negedge clk);
        song_sel = 2'(sel);
        loop_en  = lp;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    int dn, done_at;
    int notes [100];

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_note", int'(note), 0);
        chk("rst_beat", int'(beat_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // song0 one-shot
        start_song(0, 0);
        chk("s0_busy_first", int'(busy), 1);
        dn = 0; done_at = 0;
        for (int n = 1; n <= 80; n++) begin
            if (n > 1) @(negedge clk);
            if (done) begin dn++; done_at = n; end
            if (n == 6)  chk("s0_note_beat1", int'(note), 4);
            if (n == 10) chk("s0_note_beat2", int'(note), 6);
        end
        chk("s0_done_count", dn, 1);
        chk("s0_done_cycle", done_at, 65);
        chk("s0_busy_end", int'(busy), 0);

        // stop in IDLE
        pulse_stop();
        chk("idle_stop_busy", int'(busy), 0);

        // song1 looping, selection changes mid-play ignored
        start_song(1, 1);
        dn = 0;
        for (int n = 1; n <= 80; n++) begin
            if (n > 1) @(negedge clk);
            if (done) dn++;
            notes[n] = int'(note);
            if (n == 10) begin song_sel = 2'd2; loop_en = 1'b0; end
            if (n == 32) chk("s1_beat7", int'(beat_cnt), 7);
            if (n == 33) chk("s1_wrap0", int'(beat_cnt), 0);
        end
        chk("s1_period_a", notes[40], notes[8]);
        chk("s1_period_b", notes[70], notes[38]);
        chk("s1_no_done", dn, 0);
        pulse_stop();

        // song2, start and stop together
        start_song(2, 0);
        repeat (9) @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", int'(busy), 0);
        chk("ss_note", int'(note), 0);
        dn = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("ss_no_done", dn, 0);

        // song2 at beat 3, restart into song1
        start_song(2, 0);
        repeat (12) @(negedge clk);
        chk("rs_beat3", int'(beat_cnt), 3);
        start_song(1, 0);
        chk("rs_beat0", int'(beat_cnt), 0);
        chk("rs_busy", int'(busy), 1);
        chk("rs_done", int'(done), 0);
        @(negedge clk);
        chk("rs_note_f4", int'(note), 4);
        pulse_stop();

        // asynchronous reset mid-beat during song1
        start_song(1, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_note", int'(note), 0);
        chk("ar_beat", int'(beat_cnt), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1; song_sel = 2'd1; loop_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ar_first_start", int'(busy), 1);
        repeat (10) @(negedge clk);
        pulse_stop();

        // song3 one-shot
        start_song(3, 0);
        dn = 0; done_at = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) @(negedge clk);
            if (done) begin dn++; done_at = n; end
            if (n == 3) chk("s3_note", int'(note), 0);
        end
        chk("s3_done_count", dn, 1);
        chk("s3_done_cycle", done_at, 5);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
